// File: rtl/imem_loader.sv
// Program loader and run controller for the RV32I core.
// Streams a program into instruction memory, runs the core, halts it.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  core_enable,
  input  logic [31:0]           instruction,
  input  logic [31:0]           pc,
  output logic                  halted,
  output logic                  timeout,
  output logic                  load_error,
  output logic [31:0]           halt_pc,
  output logic [31:0]           cycle_count
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH     = 17'(1) << ADDR_WIDTH;
  localparam logic [31:0] LAST_CYC  = 32'(MAX_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(RST_CYCLES);
  localparam logic [6:0]  OP_HALT   = 7'b1111111;

  state_t state, state_d;

  logic [15:0] n_words, n_words_d;
  logic [15:0] word_idx, word_idx_d;
  logic [1:0]  byte_idx, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic [15:0] hold_cnt, hold_cnt_d;

  logic                  imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_d;
  logic [31:0]           imem_wdata_d;
  logic                  core_rst_d;
  logic                  core_enable_d;
  logic                  halted_d;
  logic                  timeout_d;
  logic                  load_error_d;
  logic [31:0]           halt_pc_d;
  logic [31:0]           cycle_count_d;

  logic        accept;
  logic [15:0] n_hdr;
  logic        unused_instr;

  assign byte_ready = !rst &&
    (state == S_HDR0 || state == S_HDR1 ||
     state == S_LOAD);
  assign accept       = byte_valid && byte_ready;
  assign n_hdr        = {byte_data, n_words[7:0]};
  assign unused_instr = ^instruction[31:7];

  // Next-state and next-output logic for every register
  always_comb begin
    state_d       = state;
    n_words_d     = n_words;
    word_idx_d    = word_idx;
    byte_idx_d    = byte_idx;
    asm_d         = asm_q;
    hold_cnt_d    = hold_cnt;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr;
    imem_wdata_d  = imem_wdata;
    core_rst_d    = core_rst;
    core_enable_d = core_enable;
    halted_d      = halted;
    timeout_d     = timeout;
    load_error_d  = load_error;
    halt_pc_d     = halt_pc;
    cycle_count_d = cycle_count;
    unique case (state)
      S_HDR0: begin
        if (accept) begin
          n_words_d = {8'h00, byte_data};
          state_d   = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          n_words_d  = n_hdr;
          word_idx_d = '0;
          byte_idx_d = '0;
          hold_cnt_d = '0;
          if (n_hdr == 16'd0) begin
            state_d = S_HOLD;
          end else if ({1'b0, n_hdr} > DEPTH) begin
            state_d      = S_ERROR;
            load_error_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          asm_d      = {byte_data, asm_q[23:8]};
          byte_idx_d = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx[ADDR_WIDTH-1:0];
            imem_wdata_d = {byte_data, asm_q};
            word_idx_d   = word_idx + 16'd1;
            if (word_idx == n_words - 16'd1) begin
              state_d    = S_HOLD;
              hold_cnt_d = '0;
            end
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d       = S_RUN;
          core_rst_d    = 1'b0;
          core_enable_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt + 16'd1;
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_count + 32'd1;
        if (instruction[6:0] == OP_HALT) begin
          state_d       = S_HALT;
          halt_pc_d     = pc;
          core_enable_d = 1'b0;
          halted_d      = 1'b1;
        end else if (cycle_count == LAST_CYC) begin
          state_d       = S_HALT;
          halt_pc_d     = pc;
          core_enable_d = 1'b0;
          halted_d      = 1'b1;
          timeout_d     = 1'b1;
        end
      end
      S_HALT, S_ERROR: begin
        if (start) begin
          state_d       = S_HDR0;
          halted_d      = 1'b0;
          timeout_d     = 1'b0;
          load_error_d  = 1'b0;
          cycle_count_d = '0;
          core_rst_d    = 1'b1;
          core_enable_d = 1'b0;
        end
      end
      default: state_d = S_HDR0;
    endcase
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HDR0;
      n_words     <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      asm_q       <= '0;
      hold_cnt    <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_rst    <= 1'b1;
      core_enable <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      load_error  <= 1'b0;
      halt_pc     <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_d;
      n_words     <= n_words_d;
      word_idx    <= word_idx_d;
      byte_idx    <= byte_idx_d;
      asm_q       <= asm_d;
      hold_cnt    <= hold_cnt_d;
      imem_we     <= imem_we_d;
      imem_addr   <= imem_addr_d;
      imem_wdata  <= imem_wdata_d;
      core_rst    <= core_rst_d;
      core_enable <= core_enable_d;
      halted      <= halted_d;
      timeout     <= timeout_d;
      load_error  <= load_error_d;
      halt_pc     <= halt_pc_d;
      cycle_count <= cycle_count_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed sequence with random programs,
// checked against a word-level model of load and run behaviour.
module tb_imem_loader;

  localparam int AW = 8;
  localparam int RC = 2;
  localparam int MC = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_data = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          core_enable;
  logic [31:0]   instruction;
  logic [31:0]   pc;
  logic          halted;
  logic          timeout;
  logic          load_error;
  logic [31:0]   halt_pc;
  logic [31:0]   cycle_count;

  imem_loader #(
    .ADDR_WIDTH(AW),
    .RST_CYCLES(RC),
    .MAX_CYCLES(MC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .start(start),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst(core_rst),
    .core_enable(core_enable),
    .instruction(instruction),
    .pc(pc),
    .halted(halted),
    .timeout(timeout),
    .load_error(load_error),
    .halt_pc(halt_pc),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Tiny core: pc steps by 4 while enabled, fetches the loaded program
  logic [31:0] tpc = '0;
  logic [31:0] tmem [0:255];
  int          tn = 0;
  always @(posedge clk) begin
    if (core_rst) tpc <= '0;
    else if (core_enable) tpc <= tpc + 32'd4;
  end
  assign pc = tpc;
  assign instruction = ((tpc >> 2) < 32'(tn)) ?
    tmem[tpc[9:2]] : 32'h0000_0013;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  wr_t  got[$];
  wr_t  ref_got[$];
  int   last_we_cyc = 0;
  int   en_rise_cyc = 0;
  int   hdr_cyc = 0;
  logic prev_en = 1'b0;

  // Record memory writes and the enable rising edge
  always @(negedge clk) begin
    wr_t w;
    if (imem_we === 1'b1) begin
      w.a = imem_addr;
      w.d = imem_wdata;
      got.push_back(w);
      last_we_cyc = cyc;
    end
    if (core_enable === 1'b1 && !prev_en) en_rise_cyc = cyc;
    prev_en = (core_enable === 1'b1);
  end

  int passes = 0;
  int total = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic bound_fail(input string tag);
    total++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int k;
    int g;
    g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) step();
    byte_data  = b;
    byte_valid = 1'b1;
    k = 0;
    while (byte_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) bound_fail("byte_accept");
    step();
    byte_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[6:0] == 7'h7f) w[6:0] = 7'h13;
    return w;
  endfunction

  task automatic load_prog(input logic [31:0] w[$],
                           input bit gaps);
    logic [15:0] n;
    logic [31:0] x;
    n = 16'(w.size());
    for (int i = 0; i < w.size(); i++) tmem[i] = w[i];
    tn = w.size();
    got.delete();
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    hdr_cyc = cyc;
    for (int i = 0; i < w.size(); i++) begin
      x = w[i];
      for (int j = 0; j < 4; j++) begin
        send_byte(x[8*j +: 8], gaps);
      end
    end
  endtask

  // Load result: write list, addresses, and enable latency
  task automatic check_load(input string tag,
                            input logic [31:0] w[$]);
    int k;
    k = 0;
    while (core_enable !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) bound_fail({tag, "_enable"});
    chk({tag, "_nwr"}, got.size(), w.size());
    for (int i = 0; i < w.size() && i < got.size(); i++) begin
      chk({tag, "_addr"}, 32'(got[i].a), i);
      chk({tag, "_data"}, got[i].d, w[i]);
    end
    if (w.size() == 0)
      chk({tag, "_lat"}, en_rise_cyc - hdr_cyc, RC + 1);
    else
      chk({tag, "_lat"}, en_rise_cyc - last_we_cyc, RC + 1);
    chk({tag, "_crst"}, core_rst, 0);
  endtask

  // Model of the run: word k is seen on run cycle k
  task automatic check_run(input string tag);
    int k;
    logic [31:0] e_pc;
    logic [31:0] e_cc;
    logic        e_to;
    logic [31:0] ins;
    e_pc = 0;
    e_cc = 0;
    e_to = 0;
    for (int c = 0; c < MC; c++) begin
      ins = (c < tn) ? tmem[c] : 32'h13;
      if (ins[6:0] == 7'h7f) begin
        e_pc = 32'(4 * c);
        e_cc = 32'(c + 1);
        break;
      end
      if (c == MC - 1) begin
        e_pc = 32'(4 * c);
        e_cc = 32'(MC);
        e_to = 1'b1;
      end
    end
    k = 0;
    while (halted !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) bound_fail({tag, "_halt_wait"});
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_timeout"}, timeout, e_to);
    chk({tag, "_halt_pc"}, halt_pc, e_pc);
    chk({tag, "_cycles"}, cycle_count, e_cc);
    chk({tag, "_en"}, core_enable, 0);
    chk({tag, "_crst"}, core_rst, 0);
    repeat (3) step();
    chk({tag, "_frozen"}, cycle_count, e_cc);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p1[$];
    logic [31:0] p0[$];
    logic [31:0] p4[$];
    logic [31:0] pa;
    logic [31:0] pc1[$];

    for (int i = 0; i < 256; i++) tmem[i] = '0;

    step();
    step();
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_crst", core_rst, 1);
    chk("rst_en", core_enable, 0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_lerr", load_error, 0);
    chk("rst_hpc", halt_pc, 0);
    chk("rst_cc", cycle_count, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", byte_ready, 1);

    p1 = '{32'h0010_0013, 32'h0000_00ff};
    load_prog(p1, 1'b0);
    check_load("prog", p1);
    check_run("prog");

    pulse_start();
    chk("start_halted", halted, 0);
    chk("start_cc", cycle_count, 0);
    chk("start_crst", core_rst, 1);
    chk("start_ready", byte_ready, 1);

    p0 = {};
    load_prog(p0, 1'b0);
    check_load("empty", p0);
    check_run("empty");
    pulse_start();

    got.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    byte_valid = 1'b1;
    repeat (3) step();
    byte_valid = 1'b0;
    chk("err_flag", load_error, 1);
    chk("err_ready", byte_ready, 0);
    chk("err_crst", core_rst, 1);
    chk("err_en", core_enable, 0);
    chk("err_nwr", got.size(), 0);
    pulse_start();
    chk("err_clr", load_error, 0);
    chk("err_ready2", byte_ready, 1);

    for (int i = 0; i < 4; i++) p4.push_back(rand_word());
    load_prog(p4, 1'b0);
    check_load("nogap", p4);
    ref_got = got;
    check_run("nogap");
    pulse_start();

    load_prog(p4, 1'b1);
    check_load("gap", p4);
    chk("gap_same_n", got.size(), ref_got.size());
    for (int i = 0; i < got.size() && i < ref_got.size(); i++)
      chk("gap_same_d", got[i].d, ref_got[i].d);
    check_run("gap");
    pulse_start();

    got.delete();
    pa = rand_word();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int j = 0; j < 4; j++) send_byte(pa[8*j +: 8], 1'b0);
    send_byte(8'hde, 1'b0);
    send_byte(8'had, 1'b0);
    step();
    chk("mid_nwr", got.size(), 1);
    rst = 1'b1;
    step();
    chk("mid_crst", core_rst, 1);
    chk("mid_we", imem_we, 0);
    chk("mid_addr", 32'(imem_addr), 0);
    chk("mid_cc", cycle_count, 0);
    rst = 1'b0;
    step();
    chk("mid_ready", byte_ready, 1);
    pc1.push_back(rand_word());
    load_prog(pc1, 1'b0);
    check_load("reload", pc1);
    check_run("reload");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader and run controller for the RV32I pipeline. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into instruction memory while holding the core in reset, then releases the core (`rst` low, `enable` high). It watches the fetched instruction for the halt opcode 7'b1111111 and stops the core on it, reporting the halt PC and the run-cycle count.

## Interface
- `ADDR_WIDTH`, 8: instruction memory word-address width. Depth is 2^ADDR_WIDTH words.
- `RST_CYCLES`, 2: number of cycles core reset is held after load, before `enable`.
- `MAX_CYCLES`, 1000: run-cycle limit that forces a timeout halt.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `byte_data`  in  8: stream byte.
- `byte_valid`  in  1: `byte_data` is valid.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `start`  in  1: one-cycle pulse; starts a new load from HALT or ERROR.
- `imem_we`  out  1: instruction memory write strobe.
- `imem_addr`  out  ADDR_WIDTH: word address.
- `imem_wdata`  out  32: instruction word.
- `core_rst`  out  1: drives core `rst`.
- `core_enable`  out  1: drives core `enable`.
- `instruction`  in  32: core fetched instruction (`out_instruction`).
- `pc`  in  32: core `pc_out`.
- `halted`  out  1: core stopped, by halt opcode or by timeout.
- `timeout`  out  1: halt was caused by `MAX_CYCLES`.
- `load_error`  out  1: header word count exceeded depth.
- `halt_pc`  out  32: `pc` captured at the halt.
- `cycle_count`  out  32: enabled-cycle count for the current run.

## Operation
- States: HDR0, HDR1, LOAD, HOLD, RUN, HALT, ERROR.
- Reset values:
  - state = HDR0.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_rst`=1, `core_enable`=0.
  - `halted`=0, `timeout`=0, `load_error`=0.
  - `halt_pc`=0, `cycle_count`=0.
- `byte_ready` = (state is HDR0, HDR1 or LOAD) and not `rst`. A byte is accepted on a rising edge with `byte_valid` && `byte_ready`.
- Stream format: N[7:0], N[15:8], then 4·N instruction bytes, each word least-significant byte first.
- HDR0: accept N low byte → HDR1.
- HDR1: accept N high byte.
  - N == 0 → HOLD.
  - N > 2^ADDR_WIDTH → ERROR.
  - Otherwise → LOAD; word index = 0, byte index = 0.
- LOAD: each accepted byte is shifted into the assembly register; byte index wraps 3→0.
  - On acceptance of byte 3, the next cycle outputs `imem_we`=1, `imem_addr` = word index, `imem_wdata` = {b3,b2,b1,b0}. The word index then increments.
  - After word N−1 is written → HOLD.
  - No stall on write: a byte may be accepted in the same cycle `imem_we` is high.
- HOLD: `core_rst`=1 for exactly `RST_CYCLES` cycles → RUN.
- RUN: `core_rst`=0, `core_enable`=1, `cycle_count` increments every cycle.
  - If `instruction[6:0]` == 7'b1111111: → HALT, `halt_pc` ← `pc`.
  - Else if `cycle_count` == `MAX_CYCLES`−1: → HALT, `timeout`=1, `halt_pc` ← `pc`.
  - Halt opcode takes priority over timeout in the same cycle.
- HALT: `core_enable`=0, `core_rst`=0 (register state stays observable), `halted`=1, `cycle_count` frozen.
- ERROR: `load_error`=1, `core_rst`=1, `core_enable`=0; all further bytes are refused.
- `start` in HALT or ERROR → HDR0. This clears `halted`, `timeout`, `load_error` and `cycle_count`, and sets `core_rst`=1. `start` in any other state is ignored.
- `rst` mid-load or mid-run: all state returns to reset values. Memory contents already written are left untouched, and the partial word is discarded.

## Timing
- All outputs are registered except `byte_ready`.
- Write latency: one cycle from acceptance of byte 3 to `imem_we`. `imem_we` is a single-cycle pulse per word.
- Load-done to `core_enable` rising: `RST_CYCLES`+1 cycles after the final `imem_we`.
- Halt detection: `core_enable` falls on the edge after the cycle in which the halt opcode is present on `instruction`.
- `byte_valid` may toggle freely. Gaps between bytes are allowed in every state and affect nothing but throughput.

## Test plan
- Stream 02 00 13 00 10 00 FF 00 00 00 → writes addr0=0x00100013, addr1=0x000000FF. `core_enable` rises 3 cycles after the second write. Halt on 0x...7F gives `halted`=1, `halt_pc`=fetched PC.
- Header 00 00 → no `imem_we`; `core_enable` rises 3 cycles after the header is accepted.
- Header 01 01 (N=257, ADDR_WIDTH=8) → `load_error`=1, `byte_ready`=0, `core_rst`=1. `start` → HDR0 with `load_error`=0.
- Program without a halt opcode, `MAX_CYCLES`=50 → `halted`=1, `timeout`=1, `cycle_count`=50.
- Random `byte_valid` gaps (≈50% duty) across a 4-word load → data and addresses are identical to the gapless case, and `imem_we` fires exactly 4 times.
- `rst` asserted after 6 payload bytes, then a full reload of 1 word → state returns to HDR0, first write lands at addr0 with the new data.
